// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 device-to-host frame receiver presenting make/break scan codes on key.
module ps2_keycode_rx #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  RELEASE_CODE   = 8'hF0,
    parameter logic [7:0]  INVALID_CODE   = 8'hFF,
    parameter logic [7:0]  EXT_CODE       = 8'hE0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_strobe,
    output logic       key_ext,
    output logic       frame_error,
    output logic [2:0] debug_state_out
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_ACCEPT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    key_q, key_d;
    logic          strobe_q, strobe_d;
    logic          key_ext_q, key_ext_d;
    logic          ferr_q, ferr_d;
    logic          ext_pend_q, ext_pend_d;
    logic          rel_pend_q, rel_pend_d;
    logic          clr_key_q, clr_key_d;

    logic fall, bit_in, in_frame;

    assign fall     = clk_prev_q & ~clk_sync_q[1];
    assign bit_in   = dat_sync_q[1];
    assign in_frame = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);

    // Synchronisers reset to the idle-high line level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            par_ok_q   <= 1'b0;
            to_q       <= '0;
            key_q      <= INVALID_CODE;
            strobe_q   <= 1'b0;
            key_ext_q  <= 1'b0;
            ferr_q     <= 1'b0;
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
            clr_key_q  <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            clk_prev_q <= clk_sync_q[1];
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            par_ok_q   <= par_ok_d;
            to_q       <= to_d;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
            key_ext_q  <= key_ext_d;
            ferr_q     <= ferr_d;
            ext_pend_q <= ext_pend_d;
            rel_pend_q <= rel_pend_d;
            clr_key_q  <= clr_key_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        par_ok_d   = par_ok_q;
        to_d       = to_q;
        key_d      = key_q;
        strobe_d   = 1'b0;
        key_ext_d  = key_ext_q;
        ferr_d     = 1'b0;
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;
        clr_key_d  = 1'b0;

        // Break code was shown last cycle; fall back to the idle code.
        if (clr_key_q) begin
            key_d     = INVALID_CODE;
            key_ext_d = 1'b0;
        end

        if (fall) begin
            to_d = '0;
        end else if (in_frame) begin
            to_d = (to_q == {TW{1'b1}}) ? to_q : to_q + 1'b1;
        end else begin
            to_d = '0;
        end

        if (in_frame && !fall && (to_q >= TO_LAST)) begin
            ferr_d     = 1'b1;
            state_d    = S_IDLE;
            to_d       = '0;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall && !bit_in) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        shift_d  = {bit_in, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (fall) begin
                        par_ok_d = ^{shift_q, bit_in};
                        state_d  = S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        if (bit_in && par_ok_q) begin
                            state_d = S_ACCEPT;
                        end else begin
                            ferr_d     = 1'b1;
                            state_d    = S_IDLE;
                            ext_pend_d = 1'b0;
                            rel_pend_d = 1'b0;
                        end
                    end
                end
                S_ACCEPT: begin
                    state_d = S_IDLE;
                    if (shift_q == EXT_CODE) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == RELEASE_CODE) begin
                        key_d      = RELEASE_CODE;
                        strobe_d   = 1'b1;
                        rel_pend_d = 1'b1;
                    end else begin
                        key_d      = shift_q;
                        key_ext_d  = ext_pend_q;
                        strobe_d   = 1'b1;
                        ext_pend_d = 1'b0;
                        if (rel_pend_q) begin
                            clr_key_d  = 1'b1;
                            rel_pend_d = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign key             = key_q;
    assign key_strobe      = strobe_q;
    assign key_ext         = key_ext_q;
    assign frame_error     = ferr_q;
    assign debug_state_out = state_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - self-checking bench for ps2_keycode_rx.
module tb_ps2_keycode_rx;

    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       key_strobe, key_ext, frame_error;
    logic [2:0] debug_state_out;

    ps2_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .key             (key),
        .key_strobe      (key_strobe),
        .key_ext         (key_ext),
        .frame_error     (frame_error),
        .debug_state_out (debug_state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        logic       ext;
        logic       one_clk;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       bad_par;
        logic       bad_stop;
        logic       strobe;
        logic       one_clk;
        logic [7:0] exp_key;
        logic       exp_ext;
        logic [7:0] key_after;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       vecs[19];
    int         n_checks = 0;
    int         n_pass = 0;
    int         err_cnt = 0;
    int         exp_err = 0;
    logic       pend_rev = 1'b0;
    logic       pend_hold = 1'b0;
    logic [7:0] hold_key = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            pend_rev  = 1'b0;
            pend_hold = 1'b0;
        end else begin
            if (frame_error) err_cnt++;
            if (pend_rev) begin
                check("revert_key", 32'(key), 32'hFF);
                check("revert_ext", 32'(key_ext), 32'h0);
                pend_rev = 1'b0;
            end
            if (pend_hold) begin
                check("hold_key", 32'(key), 32'(hold_key));
                pend_hold = 1'b0;
            end
            if (key_strobe) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: got key %0h expected no strobe", key);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe_key", 32'(key), 32'(mon_e.key));
                    check("strobe_ext", 32'(key_ext), 32'(mon_e.ext));
                    if (mon_e.one_clk) pend_rev = 1'b1;
                    else begin
                        pend_hold = 1'b1;
                        hold_key  = mon_e.key;
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits, input int stretch);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
            if (i == 3) repeat (stretch) @(posedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] k, input logic e, input logic one);
        exp_t x;
        x.key = k; x.ext = e; x.one_clk = one;
        sb.push_back(x);
    endtask

    initial begin
        //            b      par   stop  strb  one   key    ext   after
        vecs[0]  = '{8'h70, 1'b0, 1'b0, 1'b1, 1'b0, 8'h70, 1'b0, 8'h70};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'hF0};
        vecs[2]  = '{8'h70, 1'b0, 1'b0, 1'b1, 1'b1, 8'h70, 1'b0, 8'hFF};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 8'h1C};
        vecs[4]  = '{8'h69, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h1C};
        vecs[5]  = '{8'h69, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h1C};
        vecs[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h1C};
        vecs[7]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'hF0};
        vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hF0};
        vecs[9]  = '{8'h70, 1'b0, 1'b0, 1'b1, 1'b1, 8'h70, 1'b1, 8'hFF};
        vecs[10] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF};
        vecs[11] = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, 8'h75};
        vecs[12] = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b0, 8'h75};
        vecs[13] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'hF0};
        vecs[14] = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hF0};
        vecs[15] = '{8'h70, 1'b0, 1'b0, 1'b1, 1'b0, 8'h70, 1'b0, 8'h70};
        vecs[16] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h70};
        vecs[17] = '{8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h70};
        vecs[18] = '{8'h70, 1'b0, 1'b0, 1'b1, 1'b0, 8'h70, 1'b0, 8'h70};

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_key", 32'(key), 32'hFF);
        check("reset_strobe", 32'(key_strobe), 32'h0);
        check("reset_ferr", 32'(frame_error), 32'h0);
        check("reset_ext", 32'(key_ext), 32'h0);
        check("reset_state", 32'(debug_state_out), 32'h0);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].strobe) push_exp(vecs[i].exp_key, vecs[i].exp_ext, vecs[i].one_clk);
            if (vecs[i].bad_par || vecs[i].bad_stop) exp_err++;
            send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop, 11, 0);
            repeat ((i == 0) ? 400 : 100) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_key", i), 32'(key), 32'(vecs[i].key_after));
            check($sformatf("vec%0d_errs", i), 32'(err_cnt), 32'(exp_err));
        end

        // Inter-edge gap just under the timeout must still decode.
        push_exp(8'h4B, 1'b0, 1'b0);
        send_frame(8'h4B, 1'b0, 1'b0, 11, TO - 60);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("slow_key", 32'(key), 32'h4B);
        check("slow_errs", 32'(err_cnt), 32'(exp_err));

        // Stalled frame: start + 5 data bits, then clock held high.
        send_frame(8'h00, 1'b0, 1'b0, 6, 0);
        exp_err++;
        repeat (TO + 50) @(posedge clk);
        @(negedge clk);
        check("timeout_errs", 32'(err_cnt), 32'(exp_err));
        check("timeout_state", 32'(debug_state_out), 32'h0);
        check("timeout_key", 32'(key), 32'h4B);
        push_exp(8'h7C, 1'b0, 1'b0);
        send_frame(8'h7C, 1'b0, 1'b0, 11, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("after_timeout_key", 32'(key), 32'h7C);

        // Reset in the middle of a frame.
        send_frame(8'h55, 1'b0, 1'b0, 4, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_key", 32'(key), 32'hFF);
        check("midreset_state", 32'(debug_state_out), 32'h0);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        push_exp(8'h7C, 1'b0, 1'b0);
        send_frame(8'h7C, 1'b0, 1'b0, 11, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("after_reset_key", 32'(key), 32'h7C);
        check("final_errs", 32'(err_cnt), 32'(exp_err));
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
